// File: rtl/keccak_sched_pkg.sv
// ---------------------------------------------------------------------------
// keccak_sched_pkg
//   Shared definitions for the Keccak-style round scheduler:
//   - default round / stage / watchdog limits
//   - stage index constants (THETA .. IOTA)
//   - scheduler FSM state encoding
//   - helper to size the stage watchdog counter
// ---------------------------------------------------------------------------
package keccak_sched_pkg;

    // Default permutation geometry and stage timeout.
    localparam int NUM_ROUNDS_DEFAULT = 24;
    localparam int NUM_STAGES_DEFAULT = 5;
    localparam int TIMEOUT_DEFAULT    = 4095;

    // Stage order inside one round.
    localparam int THETA   = 0;
    localparam int ROTATE  = 1;
    localparam int PERMUTE = 2;
    localparam int CHI     = 3;
    localparam int IOTA    = 4;

    // Width of the round_idx output.
    localparam int ROUND_W = 5;

    // Scheduler states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_FINISH  = 3'd4,
        ST_ERROR   = 3'd5
    } sched_state_t;

    // Counter width able to hold the value TIMEOUT itself (12 bits for 4095).
    function automatic int wdog_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sched_watchdog.sv
// ---------------------------------------------------------------------------
// sched_watchdog
//   Per-stage wait counter. Cleared when a stage is launched, counts every
//   cycle the scheduler waits without a matching completion, and flags the
//   cycle in which the next increment would reach TIMEOUT.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset (count -> 0)
//   clear    in   synchronous clear (takes priority over enable)
//   enable   in   increment request for this cycle
//   terminal out  count == TIMEOUT-1: this wait cycle is the last one allowed
// ---------------------------------------------------------------------------
module sched_watchdog
    import keccak_sched_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int WIDTH   = wdog_width(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] LAST  = WIDTH'(TIMEOUT - 1);

    logic [WIDTH-1:0] count;

    // Saturates at TIMEOUT so it can never wrap back to a small value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + WIDTH'(1);
        end
    end

    // The FSM leaves WAIT for ERROR on the same edge that takes count to
    // TIMEOUT, so the flag is raised one value early.
    assign terminal = (count == LAST);

endmodule

// File: rtl/round_scheduler.sv
// ---------------------------------------------------------------------------
// round_scheduler
//   Sequences NUM_ROUNDS rounds of NUM_STAGES stages each (theta, rotate,
//   permute, chi, iota). Each stage is launched with a one-cycle pulse and
//   the scheduler waits for that stage's completion pulse, with a watchdog
//   that traps a stage that never answers.
//
// Stage handshake: stage_start[i] is a one-cycle launch pulse (the "valid")
//   and stage_done[i] is a one-cycle completion pulse (the "ready"). Only
//   stage_done[stage_idx] sampled while in WAIT is honoured; any bit seen in
//   another state, or for another stage, is dropped and never remembered.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   request one full permutation (sampled only in IDLE)
//   abort        in   cancel the permutation in progress (non-IDLE states)
//   stage_done   in   [NUM_STAGES] per-stage completion pulses
//   stage_start  out  [NUM_STAGES] one-hot one-cycle launch pulse
//   round_idx    out  [5] current round, holds NUM_ROUNDS-1 after finishing
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse on successful completion
//   err          out  sticky stage-timeout flag, cleared by the next start
// ---------------------------------------------------------------------------
module round_scheduler
    import keccak_sched_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT,
    parameter int NUM_STAGES = NUM_STAGES_DEFAULT,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic [ROUND_W-1:0]    round_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int STAGE_W = (NUM_STAGES < 2) ? 1 : $clog2(NUM_STAGES);
    localparam int WD_W    = wdog_width(TIMEOUT);

    localparam logic [STAGE_W-1:0] FIRST_STAGE = STAGE_W'(THETA);
    localparam logic [STAGE_W-1:0] LAST_STAGE  = STAGE_W'(NUM_STAGES - 1);
    localparam logic [ROUND_W-1:0] LAST_ROUND  = ROUND_W'(NUM_ROUNDS - 1);

    sched_state_t         state;
    sched_state_t         state_nxt;
    logic [STAGE_W-1:0]   stage_idx;
    logic [STAGE_W-1:0]   stage_idx_nxt;
    logic [ROUND_W-1:0]   round_nxt;
    logic                 err_nxt;

    logic                 stage_hit;
    logic                 wd_clear;
    logic                 wd_enable;
    logic                 wd_terminal;

    // Completion of the stage currently being waited on.
    assign stage_hit = |(stage_done & (NUM_STAGES'(1) << stage_idx));

    // Watchdog: restart on every launch, count only unanswered WAIT cycles.
    assign wd_clear  = (state == ST_LAUNCH);
    assign wd_enable = (state == ST_WAIT) && !stage_hit && !abort;

    sched_watchdog #(
        .TIMEOUT (TIMEOUT),
        .WIDTH   (WD_W)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (wd_clear),
        .enable   (wd_enable),
        .terminal (wd_terminal)
    );

    // -----------------------------------------------------------------------
    // State and counter registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            stage_idx <= FIRST_STAGE;
            round_idx <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            stage_idx <= stage_idx_nxt;
            round_idx <= round_nxt;
            err       <= err_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and counter update
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        stage_idx_nxt = stage_idx;
        round_nxt     = round_idx;
        err_nxt       = err;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    stage_idx_nxt = FIRST_STAGE;
                    round_nxt     = '0;
                    err_nxt       = 1'b0;
                    state_nxt     = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                state_nxt = ST_WAIT;
            end

            ST_WAIT: begin
                // A completion in the last allowed cycle still counts.
                if (stage_hit) begin
                    state_nxt = ST_ADVANCE;
                end else if (wd_terminal) begin
                    state_nxt = ST_ERROR;
                    err_nxt   = 1'b1;
                end
            end

            ST_ADVANCE: begin
                if (stage_idx != LAST_STAGE) begin
                    stage_idx_nxt = stage_idx + STAGE_W'(1);
                    state_nxt     = ST_LAUNCH;
                end else begin
                    stage_idx_nxt = FIRST_STAGE;
                    // The last round goes to FINISH instead of incrementing,
                    // so round_idx never wraps.
                    if (round_idx == LAST_ROUND) begin
                        state_nxt = ST_FINISH;
                    end else begin
                        round_nxt = round_idx + ROUND_W'(1);
                        state_nxt = ST_LAUNCH;
                    end
                end
            end

            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end

            ST_ERROR: begin
                state_nxt = ST_ERROR;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Abort beats everything else, including a completion in the same
        // cycle: progress freezes where it is and err keeps its value.
        if (abort && (state != ST_IDLE)) begin
            state_nxt     = ST_IDLE;
            stage_idx_nxt = stage_idx;
            round_nxt     = round_idx;
            err_nxt       = err;
        end
    end

    // -----------------------------------------------------------------------
    // Moore outputs
    // -----------------------------------------------------------------------
    always_comb begin
        stage_start = '0;
        if (state == ST_LAUNCH) begin
            stage_start = NUM_STAGES'(1) << stage_idx;
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FINISH);

endmodule

// File: tb/tb_round_scheduler.sv
// ---------------------------------------------------------------------------
// tb_round_scheduler
//   Self-checking bench for round_scheduler. The expected output timeline of
//   a permutation is computed from the stage response delays: every stage
//   costs one launch cycle, its wait cycles and one advance cycle; a stage
//   that never answers waits TIMEOUT cycles and then sits in error.
// ---------------------------------------------------------------------------
module tb_round_scheduler;
    import keccak_sched_pkg::*;

    localparam int NR   = 24;
    localparam int NS   = 5;
    localparam int TO   = 15;
    localparam int NTOT = NR * NS;
    localparam int MAXC = 1024;
    localparam int W    = NS + 5 + 3;   // {stage_start, round_idx, busy, done, err}

    // -----------------------------------------------------------------------
    // Clock / reset / DUT
    // -----------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [NS-1:0] stage_done = '0;
    logic [NS-1:0] stage_start;
    logic [4:0]    round_idx;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    round_scheduler #(
        .NUM_ROUNDS (NR),
        .NUM_STAGES (NS),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .stage_done  (stage_done),
        .stage_start (stage_start),
        .round_idx   (round_idx),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // -----------------------------------------------------------------------
    // Bench state
    // -----------------------------------------------------------------------
    int            checks = 0;
    int            errors = 0;
    int            dly [NTOT];          // wait cycles per stage, 0 = never answers
    int            lt  [NTOT];          // model launch cycle of each stage
    logic [W-1:0]  exp_q [$];           // expected outputs for t = 1, 2, ...
    int            trace_len = 0;
    logic          check_en = 1'b0;
    logic          noise_en = 1'b0;
    logic          wrong_mode = 1'b0;
    int            t = 0;               // cycles since the start-sampling edge

    logic [NS-1:0] obs_ss   [MAXC];
    logic [4:0]    obs_ri   [MAXC];
    logic          obs_busy [MAXC];
    logic          obs_done [MAXC];
    logic          obs_err  [MAXC];

    always @(posedge clk) t <= check_en ? t + 1 : 0;

    task automatic chk(input string nm, input int cyc, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s t=%0d got %0d expected %0d", nm, cyc, act, expv);
        end
    endtask

    function automatic logic [W-1:0] pack(input int ss, input int ri, input bit b, input bit d, input bit e);
        return {NS'(ss), 5'(ri), b, d, e};
    endfunction

    // -----------------------------------------------------------------------
    // Reference timeline. ta > 0: abort sampled at the end of cycle ta.
    // -----------------------------------------------------------------------
    function automatic void build_model(input int ta);
        int           tt;
        int           r;
        int           s;
        bit           hit_err;
        logic [W-1:0] e;
        exp_q.delete();
        tt      = 1;
        hit_err = 1'b0;
        for (int g = 0; g < NTOT && !hit_err; g++) begin
            r     = g / NS;
            s     = g % NS;
            lt[g] = tt;
            exp_q.push_back(pack(1 << s, r, 1'b1, 1'b0, 1'b0));
            tt++;
            if (dly[g] == 0) begin
                for (int k = 0; k < TO; k++) exp_q.push_back(pack(0, r, 1'b1, 1'b0, 1'b0));
                for (int k = 0; k < 20; k++) exp_q.push_back(pack(0, r, 1'b1, 1'b0, 1'b1));
                hit_err = 1'b1;
            end else begin
                for (int k = 0; k < dly[g]; k++) exp_q.push_back(pack(0, r, 1'b1, 1'b0, 1'b0));
                exp_q.push_back(pack(0, r, 1'b1, 1'b0, 1'b0));
                tt += dly[g] + 1;
            end
        end
        if (!hit_err) begin
            exp_q.push_back(pack(0, NR - 1, 1'b1, 1'b1, 1'b0));
            for (int k = 0; k < 5; k++) exp_q.push_back(pack(0, NR - 1, 1'b0, 1'b0, 1'b0));
        end
        if (ta > 0) begin
            e = exp_q[ta - 1];
            while (exp_q.size() > ta) void'(exp_q.pop_back());
            for (int k = 0; k < 5; k++) exp_q.push_back(pack(0, int'(e[7:3]), 1'b0, 1'b0, e[0]));
        end
        trace_len = exp_q.size() + 1;
    endfunction

    // -----------------------------------------------------------------------
    // Scoreboard: one expected entry per cycle while a trace is active
    // -----------------------------------------------------------------------
    always @(negedge clk) begin : compare_proc
        logic [W-1:0] e;
        if (check_en && t >= 1 && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (t < MAXC) begin
                obs_ss[t]   = stage_start;
                obs_ri[t]   = round_idx;
                obs_busy[t] = busy;
                obs_done[t] = done;
                obs_err[t]  = err;
            end
            chk("stage_start", t, int'(stage_start), int'(e[W-1 -: NS]));
            chk("round_idx",   t, int'(round_idx),   int'(e[7:3]));
            chk("busy",        t, int'(busy),        int'(e[2]));
            chk("done",        t, int'(done),        int'(e[1]));
            chk("err",         t, int'(err),         int'(e[0]));
        end
    end

    // -----------------------------------------------------------------------
    // Stage responder: answers each launch after dly[] cycles, optionally
    // sprinkling bits that the scheduler must ignore.
    // -----------------------------------------------------------------------
    always @(negedge clk) begin : responder
        int            cd;
        int            gs;
        int            cur;
        logic [NS-1:0] nz;
        logic [NS-1:0] bit_c;
        if (!check_en) begin
            cd         = 0;
            gs         = 0;
            cur        = 0;
            stage_done = '0;
        end else begin
            nz    = noise_en ? NS'($urandom_range(0, 31) & $urandom_range(0, 31)) : '0;
            bit_c = NS'(1) << cur;
            if (stage_start != '0) begin
                // Launch cycle: any pattern, including the awaited bit.
                cur = gs % NS;
                cd  = (gs < NTOT) ? dly[gs] : 0;
                gs++;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    nz = nz | bit_c;
                end else begin
                    nz = nz & ~bit_c;
                    if (wrong_mode && gs == 2) nz = 5'b00100;
                end
            end else begin
                nz = nz & ~bit_c;
            end
            stage_done = nz;
        end
    end

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic set_delays(input int lo, input int hi);
        for (int g = 0; g < NTOT; g++) dly[g] = $urandom_range(lo, hi);
    endtask

    // ta: abort cycle; ts_g / tr_g: stage whose launch positions a busy start
    // pulse or a mid-cycle reset (-1 = none).
    task automatic run_perm(input int ta, input int ts_g, input int tr_g);
        int ts;
        int tr;
        build_model(ta);
        ts = (ts_g >= 0) ? lt[ts_g] + 1 : -1;
        tr = (tr_g >= 0) ? lt[tr_g] : -1;
        @(negedge clk);
        start    = 1'b1;
        check_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (t < trace_len) begin
            abort = (t == ta);
            start = (t == ts);
            if (t == tr) begin
                #2;
                check_en = 1'b0;
                rst      = 1'b1;
                #1;
                chk("rst_stage_start", t, int'(stage_start), 0);
                chk("rst_round_idx",   t, int'(round_idx),   0);
                chk("rst_busy",        t, int'(busy),        0);
                chk("rst_done",        t, int'(done),        0);
                chk("rst_err",         t, int'(err),         0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            @(negedge clk);
        end
        abort    = 1'b0;
        start    = 1'b0;
        check_en = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
    endtask

    function automatic int sum_done();
        int n = 0;
        for (int k = 1; k < trace_len && k < MAXC; k++) n += int'(obs_done[k]);
        return n;
    endfunction

    function automatic int count_launch();
        int n = 0;
        for (int k = 1; k < trace_len && k < MAXC; k++) n += (obs_ss[k] != '0) ? 1 : 0;
        return n;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout t=%0d got running expected finished", t);
        $fatal(1, "bench time limit");
    end

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_stage_start", 0, int'(stage_start), 0);
        chk("reset_round_idx",   0, int'(round_idx),   0);
        chk("reset_busy",        0, int'(busy),        0);
        chk("reset_done",        0, int'(done),        0);
        chk("reset_err",         0, int'(err),         0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal: every stage answers in its first wait cycle.
        set_delays(1, 1);
        noise_en = 1'b0;
        run_perm(-1, -1, -1);
        chk("nom_first_launch", 1,   int'(obs_ss[1]),   1 << THETA);
        chk("nom_first_round",  1,   int'(obs_ri[1]),   0);
        chk("nom_second_launch", 4,  int'(obs_ss[4]),   1 << ROTATE);
        chk("nom_last_launch",  358, int'(obs_ss[358]), 1 << IOTA);
        chk("nom_last_round",   358, int'(obs_ri[358]), 23);
        chk("nom_done_361",     361, int'(obs_done[361]), 1);
        chk("nom_done_count",   0,   sum_done(),       1);
        chk("nom_launches",     0,   count_launch(),   120);
        chk("nom_round_held",   362, int'(obs_ri[362]), 23);
        chk("nom_idle_after",   362, int'(obs_busy[362]), 0);

        // Random delays with ignored noise; a start pulse at round 5.
        for (int n = 0; n < 3; n++) begin
            set_delays(1, 4);
            noise_en = 1'b1;
            run_perm(-1, 25, -1);
            chk("rand_done_count", n, sum_done(),     1);
            chk("rand_launches",   n, count_launch(), 120);
        end
        noise_en = 1'b0;

        // Wrong-stage completion during round 0 stage 1.
        set_delays(1, 1);
        dly[1]     = 3;
        wrong_mode = 1'b1;
        run_perm(-1, -1, -1);
        wrong_mode = 1'b0;
        chk("wrong_no_advance", 7, int'(obs_ss[7]), 0);
        chk("wrong_advance",    8, int'(obs_ss[8]), 0);
        chk("wrong_launch2",    9, int'(obs_ss[9]), 5'b00100);

        // Stage 3 never answers: timeout, then abort out of ERROR.
        set_delays(1, 1);
        dly[3] = 0;
        run_perm(31, -1, -1);
        chk("to_err_before", 25, int'(obs_err[25]),  0);
        chk("to_err_set",    26, int'(obs_err[26]),  1);
        chk("to_busy_err",   31, int'(obs_busy[31]), 1);
        chk("to_abort_idle", 32, int'(obs_busy[32]), 0);
        chk("to_err_kept",   32, int'(obs_err[32]),  1);
        chk("to_no_done",    0,  sum_done(),         0);
        chk("to_err_idle",   0,  int'(err),          1);

        // Next start clears err; abort collides with the final stage's done.
        set_delays(1, 1);
        run_perm(359, -1, -1);
        chk("err_cleared",     1,   int'(obs_err[1]),    0);
        chk("abort_idle",      360, int'(obs_busy[360]), 0);
        chk("abort_round",     360, int'(obs_ri[360]),   23);
        chk("abort_no_done",   0,   sum_done(),          0);

        // Asynchronous reset at the round 10 launch, then a fresh run.
        set_delays(1, 1);
        run_perm(-1, -1, 50);
        set_delays(1, 2);
        run_perm(-1, -1, -1);
        chk("post_rst_launch", 1, int'(obs_ss[1]), 1 << THETA);
        chk("post_rst_round",  1, int'(obs_ri[1]), 0);
        chk("post_rst_done",   0, sum_done(),      1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
